// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared state encoding, coin codes and timing defaults for the
//                vending dispenser back end.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRIVE     = 3'd1,
        WAIT_DROP = 3'd2,
        EJECT     = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // Coin/request codes shared with the front-end controller
    localparam logic [1:0] c_RS1 = 2'd1;
    localparam logic [1:0] c_RS2 = 2'd2;

    localparam int c_DEF_MOTOR_CYCLES = 4;
    localparam int c_DEF_DROP_TIMEOUT = 15;
    localparam int c_DEF_EJECT_CYCLES = 3;

    // Bits needed to hold (largest duration - 1) in the shared timer
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_timer
//  Description : Loadable down-counter; expired is high while the count is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : vend_dispenser
//  Description : Runs the product motor, waits for the drop sensor, pays out
//                change, and tracks busy/fault/overrun and the vend count.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = c_DEF_MOTOR_CYCLES,
    parameter int DROP_TIMEOUT = c_DEF_DROP_TIMEOUT,
    parameter int EJECT_CYCLES = c_DEF_EJECT_CYCLES,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             product,
    input  logic             change,
    input  logic             drop_sensor,
    input  logic             clear_fault,
    output logic             motor_on,
    output logic             coin_eject,
    output logic             busy,
    output logic             fault,
    output logic             overrun,
    output logic [CNT_W-1:0] vend_count
);

    localparam int TMR_W = tmr_width(MOTOR_CYCLES, DROP_TIMEOUT, EJECT_CYCLES);

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic               pend_chg_q, pend_chg_d;
    logic               chg_q, chg_d;
    logic               seen_q, seen_d;
    logic               ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               motor_q, eject_q, busy_q, fault_q, ovr_q;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_expired;

    vend_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_chg_d = pend_chg_q;
        chg_d      = chg_q;
        seen_d     = seen_q;
        cnt_d      = cnt_q;
        ovr_d      = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        unique case (state_q)
            IDLE: begin
                if (product) begin
                    state_d   = DRIVE;
                    chg_d     = change;
                    seen_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(MOTOR_CYCLES - 1);
                end else if (pend_q) begin
                    state_d   = DRIVE;
                    chg_d     = pend_chg_q;
                    pend_d    = 1'b0;
                    seen_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(MOTOR_CYCLES - 1);
                end
            end
            DRIVE: begin
                if (drop_sensor) seen_d = 1'b1;
                if (tmr_expired) begin
                    state_d   = WAIT_DROP;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(DROP_TIMEOUT - 1);
                end
            end
            WAIT_DROP: begin
                // A drop seen in the final cycle still beats the timeout
                if (seen_q || drop_sensor) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (chg_q) begin
                        state_d   = EJECT;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(EJECT_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                if (tmr_expired) state_d = IDLE;
            end
            FAULT: begin
                if (clear_fault) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (product && (state_q != IDLE)) begin
            if ((state_q == FAULT) || pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_chg_d = change;
            end
        end

        if (state_d == FAULT) pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_chg_q <= 1'b0;
            chg_q      <= 1'b0;
            seen_q     <= 1'b0;
            cnt_q      <= '0;
            motor_q    <= 1'b0;
            eject_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_chg_q <= pend_chg_d;
            chg_q      <= chg_d;
            seen_q     <= seen_d;
            cnt_q      <= cnt_d;
            motor_q    <= (state_d == DRIVE);
            eject_q    <= (state_d == EJECT);
            busy_q     <= (state_d != IDLE);
            fault_q    <= (state_d == FAULT);
            ovr_q      <= ovr_d;
        end
    end

    assign motor_on   = motor_q;
    assign coin_eject = eject_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign overrun    = ovr_q;
    assign vend_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_dispenser
//  Description : Directed self-checking bench for vend_dispenser (8-bit and
//                2-bit count instances share the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       reset, product, change, drop_sensor, clear_fault;
    logic       motor_on, coin_eject, busy, fault, overrun;
    logic [7:0] vend_count;
    logic       m2_motor, m2_coin, m2_busy, m2_fault, m2_ovr;
    logic [1:0] vend_count2;

    int checks   = 0;
    int failures = 0;

    logic       e_m, e_c, e_b, e_f, e_o;
    logic [7:0] e_n;

    always #5 clk = ~clk;

    vend_dispenser dut (
        .clk(clk), .reset(reset), .product(product), .change(change),
        .drop_sensor(drop_sensor), .clear_fault(clear_fault),
        .motor_on(motor_on), .coin_eject(coin_eject), .busy(busy),
        .fault(fault), .overrun(overrun), .vend_count(vend_count)
    );

    vend_dispenser #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .product(product), .change(change),
        .drop_sensor(drop_sensor), .clear_fault(clear_fault),
        .motor_on(m2_motor), .coin_eject(m2_coin), .busy(m2_busy),
        .fault(m2_fault), .overrun(m2_ovr), .vend_count(vend_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in "cycle 0" with both DUTs idle
    task automatic do_reset();
        reset = 1'b1; product = 1'b0; change = 1'b0;
        drop_sensor = 1'b0; clear_fault = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (motor_on !== 1'b0)     begin failures++; $display("FAIL reset.motor_on got=%b exp=0", motor_on); end
        checks++; if (coin_eject !== 1'b0)   begin failures++; $display("FAIL reset.coin_eject got=%b exp=0", coin_eject); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset.busy got=%b exp=0", busy); end
        checks++; if (fault !== 1'b0)        begin failures++; $display("FAIL reset.fault got=%b exp=0", fault); end
        checks++; if (overrun !== 1'b0)      begin failures++; $display("FAIL reset.overrun got=%b exp=0", overrun); end
        checks++; if (vend_count !== 8'd0)   begin failures++; $display("FAIL reset.vend_count got=%0d exp=0", vend_count); end
        checks++; if ({m2_motor, m2_coin, m2_busy, m2_fault, m2_ovr} !== 5'b0)
                                             begin failures++; $display("FAIL reset.dut2_outs got=%b exp=00000", {m2_motor, m2_coin, m2_busy, m2_fault, m2_ovr}); end
        checks++; if (vend_count2 !== 2'd0)  begin failures++; $display("FAIL reset.dut2_count got=%0d exp=0", vend_count2); end
    endtask

    task automatic test_basic(input bit chg);
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            e_m = (c >= 11 && c <= 14);
            e_c = chg && (c >= 17 && c <= 19);
            e_b = (c >= 11 && c <= (chg ? 19 : 16));
            e_n = (c >= 17) ? 8'd1 : 8'd0;
            checks++; if (motor_on !== e_m)     begin failures++; $display("FAIL basic%0d.motor_on cyc=%0d got=%b exp=%b", chg, c, motor_on, e_m); end
            checks++; if (coin_eject !== e_c)   begin failures++; $display("FAIL basic%0d.coin_eject cyc=%0d got=%b exp=%b", chg, c, coin_eject, e_c); end
            checks++; if (busy !== e_b)         begin failures++; $display("FAIL basic%0d.busy cyc=%0d got=%b exp=%b", chg, c, busy, e_b); end
            checks++; if (vend_count !== e_n)   begin failures++; $display("FAIL basic%0d.vend_count cyc=%0d got=%0d exp=%0d", chg, c, vend_count, e_n); end
            checks++; if (fault !== 1'b0)       begin failures++; $display("FAIL basic%0d.fault cyc=%0d got=%b exp=0", chg, c, fault); end
            product     = (c == 10);
            change      = chg && (c == 10);
            drop_sensor = (c == 16);
            step();
        end
    endtask

    task automatic test_fault();
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            e_m = (c >= 11 && c <= 14);
            e_f = (c >= 30 && c <= 32);
            e_b = (c >= 11 && c <= 32);
            e_o = (c == 32);
            checks++; if (motor_on !== e_m)     begin failures++; $display("FAIL fault.motor_on cyc=%0d got=%b exp=%b", c, motor_on, e_m); end
            checks++; if (fault !== e_f)        begin failures++; $display("FAIL fault.fault cyc=%0d got=%b exp=%b", c, fault, e_f); end
            checks++; if (busy !== e_b)         begin failures++; $display("FAIL fault.busy cyc=%0d got=%b exp=%b", c, busy, e_b); end
            checks++; if (overrun !== e_o)      begin failures++; $display("FAIL fault.overrun cyc=%0d got=%b exp=%b", c, overrun, e_o); end
            checks++; if (vend_count !== 8'd0)  begin failures++; $display("FAIL fault.vend_count cyc=%0d got=%0d exp=0", c, vend_count); end
            product     = (c == 10) || (c == 31);
            clear_fault = (c == 32);
            step();
        end
        clear_fault = 1'b0;
    endtask

    task automatic test_drop_at_timeout();
        do_reset();
        for (int c = 0; c <= 33; c++) begin
            e_b = (c >= 11 && c <= 29);
            e_n = (c >= 30) ? 8'd1 : 8'd0;
            checks++; if (busy !== e_b)         begin failures++; $display("FAIL edge_drop.busy cyc=%0d got=%b exp=%b", c, busy, e_b); end
            checks++; if (fault !== 1'b0)       begin failures++; $display("FAIL edge_drop.fault cyc=%0d got=%b exp=0", c, fault); end
            checks++; if (vend_count !== e_n)   begin failures++; $display("FAIL edge_drop.vend_count cyc=%0d got=%0d exp=%0d", c, vend_count, e_n); end
            product     = (c == 10);
            drop_sensor = (c == 29);
            step();
        end
    endtask

    // third: 0 = second request arrives as the FSM returns to IDLE; 1 = three requests
    task automatic test_back_to_back(input bit third);
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            e_m = (c >= 11 && c <= 14) || (c >= 17 && c <= 20);
            e_b = (c >= 11 && c <= 15) || (c >= 17 && c <= 21);
            e_o = third && (c == 15);
            e_n = (c >= 22) ? 8'd2 : (c >= 16) ? 8'd1 : 8'd0;
            checks++; if (motor_on !== e_m)     begin failures++; $display("FAIL b2b%0d.motor_on cyc=%0d got=%b exp=%b", third, c, motor_on, e_m); end
            checks++; if (busy !== e_b)         begin failures++; $display("FAIL b2b%0d.busy cyc=%0d got=%b exp=%b", third, c, busy, e_b); end
            checks++; if (overrun !== e_o)      begin failures++; $display("FAIL b2b%0d.overrun cyc=%0d got=%b exp=%b", third, c, overrun, e_o); end
            checks++; if (vend_count !== e_n)   begin failures++; $display("FAIL b2b%0d.vend_count cyc=%0d got=%0d exp=%0d", third, c, vend_count, e_n); end
            checks++; if (coin_eject !== 1'b0)  begin failures++; $display("FAIL b2b%0d.coin_eject cyc=%0d got=%b exp=0", third, c, coin_eject); end
            product     = third ? (c == 10 || c == 12 || c == 14) : (c == 10 || c == 15);
            drop_sensor = (c == 12) || (c == 18);
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            e_m = (c >= 11 && c <= 13);
            checks++; if (motor_on !== e_m)     begin failures++; $display("FAIL rstmid.motor_on cyc=%0d got=%b exp=%b", c, motor_on, e_m); end
            checks++; if (busy !== e_m)         begin failures++; $display("FAIL rstmid.busy cyc=%0d got=%b exp=%b", c, busy, e_m); end
            checks++; if ({coin_eject, fault, overrun} !== 3'b000)
                                                begin failures++; $display("FAIL rstmid.other_outs cyc=%0d got=%b exp=000", c, {coin_eject, fault, overrun}); end
            checks++; if (vend_count !== 8'd0)  begin failures++; $display("FAIL rstmid.vend_count cyc=%0d got=%0d exp=0", c, vend_count); end
            product     = (c == 10) || (c == 12);
            reset       = (c == 13);
            drop_sensor = (c >= 20 && c <= 22);
            step();
        end
        reset = 1'b0; drop_sensor = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            e_m = 1'b0; e_b = 1'b0; n = 0;
            for (int k = 0; k < 5; k++) begin
                if (c >= 11 + 8*k && c <= 14 + 8*k) e_m = 1'b1;
                if (c >= 11 + 8*k && c <= 15 + 8*k) e_b = 1'b1;
                if (c >= 16 + 8*k) n++;
            end
            checks++; if (vend_count2 !== 2'(n)) begin failures++; $display("FAIL wrap.dut2_count cyc=%0d got=%0d exp=%0d", c, vend_count2, n % 4); end
            checks++; if (vend_count !== 8'(n))  begin failures++; $display("FAIL wrap.vend_count cyc=%0d got=%0d exp=%0d", c, vend_count, n); end
            checks++; if (m2_motor !== e_m)      begin failures++; $display("FAIL wrap.dut2_motor cyc=%0d got=%b exp=%b", c, m2_motor, e_m); end
            checks++; if (m2_busy !== e_b)       begin failures++; $display("FAIL wrap.dut2_busy cyc=%0d got=%b exp=%b", c, m2_busy, e_b); end
            product     = (c >= 10 && c <= 42 && (c - 10) % 8 == 0);
            drop_sensor = (c >= 12 && c <= 44 && (c - 12) % 8 == 0);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_fault();
        test_drop_at_timeout();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
